// File: rtl/prog_loader_pkg.sv
// Shared definitions for the serial program loader and the CPU instruction RAM.
package prog_loader_pkg;

  localparam int unsigned RamAddrW = 11;
  localparam logic [7:0] SyncDefault = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StAhi,
    StAlo,
    StCnt,
    StData,
    StCsum
  } load_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling, glitch and framing checks.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 139
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RX,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e       state_q;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= RxIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      data       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state_q)
        RxIdle: begin
          // Start only on a falling edge so a line held low after a framing error is not re-read.
          if (rx_prev_q && !rx_sync_q) begin
            state_q <= RxStart;
            cnt_q   <= '0;
          end
        end
        RxStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_sync_q ? RxIdle : RxData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (cnt_q == BitLast) begin
            cnt_q     <= '0;
            data      <= {rx_sync_q, data[7:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_q <= RxStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            state_q <= RxIdle;
            if (rx_sync_q) byte_valid <= 1'b1;
            else           frame_err  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: parses framed UART images and writes 32-bit words into instruction RAM.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 139,
  parameter int unsigned TIMEOUT      = 160000,
  parameter logic [7:0]  SYNC         = SyncDefault
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                RX,
  output logic [RamAddrW-1:0] WADDR,
  output logic [31:0]         WDATA,
  output logic                WEN,
  output logic                CPU_HOLD,
  output logic                DONE,
  output logic                ERR
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  logic [7:0] rx_data;
  logic       byte_valid;
  logic       frame_err;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .RX        (RX),
    .data      (rx_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  load_state_e     state_q;
  logic [2:0]      addr_hi_q;
  logic [23:0]     word_q;
  logic [1:0]      byte_idx_q;
  logic [8:0]      words_q;
  logic [7:0]      csum_q;
  logic [TmoW-1:0] tmo_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      addr_hi_q  <= '0;
      word_q     <= '0;
      byte_idx_q <= '0;
      words_q    <= '0;
      csum_q     <= '0;
      tmo_q      <= '0;
      WADDR      <= '0;
      WDATA      <= '0;
      WEN        <= 1'b0;
      CPU_HOLD   <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      WEN  <= 1'b0;
      DONE <= 1'b0;
      if (WEN) WADDR <= WADDR + 1'b1;

      // Counter holds cycles elapsed since the last byte, so it reaches TIMEOUT on the abort cycle.
      if (byte_valid)            tmo_q <= TmoW'(1);
      else if (state_q == StIdle) tmo_q <= '0;
      else                       tmo_q <= tmo_q + 1'b1;

      if (byte_valid) begin
        unique case (state_q)
          StIdle: begin
            if (rx_data == SYNC) begin
              state_q    <= StAhi;
              CPU_HOLD   <= 1'b1;
              ERR        <= 1'b0;
              csum_q     <= '0;
              byte_idx_q <= '0;
            end
          end
          StAhi: begin
            addr_hi_q <= rx_data[2:0];
            csum_q    <= csum_q ^ rx_data;
            state_q   <= StAlo;
          end
          StAlo: begin
            WADDR   <= {addr_hi_q, rx_data};
            csum_q  <= csum_q ^ rx_data;
            state_q <= StCnt;
          end
          StCnt: begin
            words_q <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            csum_q  <= csum_q ^ rx_data;
            state_q <= StData;
          end
          StData: begin
            csum_q     <= csum_q ^ rx_data;
            word_q     <= {word_q[15:0], rx_data};
            byte_idx_q <= byte_idx_q + 1'b1;
            if (byte_idx_q == 2'd3) begin
              WDATA   <= {word_q, rx_data};
              WEN     <= 1'b1;
              words_q <= words_q - 1'b1;
              if (words_q == 9'd1) state_q <= StCsum;
            end
          end
          StCsum: begin
            state_q <= StIdle;
            if (rx_data == csum_q) begin
              DONE     <= 1'b1;
              CPU_HOLD <= 1'b0;
            end else begin
              ERR <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end else if (state_q != StIdle && (frame_err || tmo_q == TmoLast)) begin
        ERR     <= 1'b1;
        state_q <= StIdle;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scoreboarded RAM writes plus per-scenario checks.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int unsigned CPB = 8;
  localparam int unsigned TMO = 400;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        RX;
  logic [10:0] WADDR;
  logic [31:0] WDATA;
  logic        WEN, CPU_HOLD, DONE, ERR;

  always #5 CLK = ~CLK;

  prog_loader #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT     (TMO),
    .SYNC        (8'hA5)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .RX      (RX),
    .WADDR   (WADDR),
    .WDATA   (WDATA),
    .WEN     (WEN),
    .CPU_HOLD(CPU_HOLD),
    .DONE    (DONE),
    .ERR     (ERR)
  );

  int checks = 0, passed = 0;
  int sb_checks = 0, sb_passed = 0;
  int done_cnt = 0, bv_cnt = 0, cyc = 0, last_bv = 0;
  logic        prev_wen = 1'b0;
  logic [42:0] exp_q[$];
  logic [31:0] wq[$];

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (dut.u_rx.byte_valid) begin
      bv_cnt  <= bv_cnt + 1;
      last_bv <= cyc;
    end
  end

  // Scoreboard: every write must match the oldest expected {addr, data}.
  always @(negedge CLK) begin
    logic [42:0] e;
    if (WEN) begin
      sb_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_wen: got addr=%h data=%h, required no write", WADDR, WDATA);
      end else begin
        e = exp_q.pop_front();
        if ({WADDR, WDATA} !== e)
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                   WADDR, WDATA, e[42:32], e[31:0]);
        else sb_passed++;
      end
      sb_checks++;
      if (prev_wen) $display("FAIL wen_spacing: got WEN on consecutive cycles, required gap");
      else sb_passed++;
    end
    if (DONE) begin
      done_cnt++;
      sb_checks++;
      if (CPU_HOLD !== 1'b0) $display("FAIL done_hold: got CPU_HOLD=%b with DONE, required 0", CPU_HOLD);
      else sb_passed++;
    end
    prev_wen = WEN;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(negedge CLK);
    RX = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge CLK);
    end
    RX = stop_ok;
    repeat (CPB) @(negedge CLK);
    RX = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  // Sends header, words from wq and checksum; pushes the expected writes as it goes.
  task automatic send_body(input logic [10:0] addr, input int n, input logic [7:0] flip);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [31:0] w;
    logic [10:0] a;
    cs = 8'h00;
    b = {5'b0, addr[10:8]}; cs ^= b; send_byte(b, 1'b1);
    b = addr[7:0];          cs ^= b; send_byte(b, 1'b1);
    b = n[7:0];             cs ^= b; send_byte(b, 1'b1);
    for (int i = 0; i < n; i++) begin
      w = wq.pop_front();
      a = addr + i[10:0];
      exp_q.push_back({a, w});
      for (int k = 3; k >= 0; k--) begin
        b = w[8*k +: 8];
        cs ^= b;
        send_byte(b, 1'b1);
      end
    end
    send_byte(cs ^ flip, 1'b1);
    repeat (4) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [10:0] addr, input int n, input logic [7:0] flip);
    send_byte(8'hA5, 1'b1);
    send_body(addr, n, flip);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    RX    = 1'b1;
    repeat (3) @(negedge CLK);
    checks += 6;
    if (WADDR !== 11'h000) $display("FAIL reset_waddr: got %h, required 000", WADDR); else passed++;
    if (WDATA !== 32'h0)   $display("FAIL reset_wdata: got %h, required 0", WDATA); else passed++;
    if (WEN !== 1'b0)      $display("FAIL reset_wen: got %b, required 0", WEN); else passed++;
    if (CPU_HOLD !== 1'b0) $display("FAIL reset_hold: got %b, required 0", CPU_HOLD); else passed++;
    if (DONE !== 1'b0)     $display("FAIL reset_done: got %b, required 0", DONE); else passed++;
    if (ERR !== 1'b0)      $display("FAIL reset_err: got %b, required 0", ERR); else passed++;
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_single_word();
    int d0;
    d0 = done_cnt;
    wq.push_back(32'h20000001);
    send_frame(11'h010, 1, 8'h00);
    checks += 5;
    if (done_cnt !== d0 + 1) $display("FAIL single_done: got %0d pulses, required 1", done_cnt - d0); else passed++;
    if (CPU_HOLD !== 1'b0) $display("FAIL single_hold: got %b, required 0", CPU_HOLD); else passed++;
    if (ERR !== 1'b0) $display("FAIL single_err: got %b, required 0", ERR); else passed++;
    if (exp_q.size() != 0) $display("FAIL single_writes: got %0d missing, required 0", exp_q.size()); else passed++;
    if (WADDR !== 11'h011) $display("FAIL single_waddr: got %h, required 011", WADDR); else passed++;
  endtask

  task automatic test_wrap();
    int d0;
    d0 = done_cnt;
    wq.push_back(32'h11223344);
    wq.push_back(32'h55667788);
    send_frame(11'h7FF, 2, 8'h00);
    checks += 3;
    if (done_cnt !== d0 + 1) $display("FAIL wrap_done: got %0d pulses, required 1", done_cnt - d0); else passed++;
    if (exp_q.size() != 0) $display("FAIL wrap_writes: got %0d missing, required 0", exp_q.size()); else passed++;
    if (WADDR !== 11'h001) $display("FAIL wrap_waddr: got %h, required 001", WADDR); else passed++;
  endtask

  task automatic test_bad_csum();
    int d0;
    d0 = done_cnt;
    wq.push_back(32'h20000001);
    send_frame(11'h010, 1, 8'h10);
    checks += 4;
    if (done_cnt !== d0) $display("FAIL bad_done: got %0d pulses, required 0", done_cnt - d0); else passed++;
    if (ERR !== 1'b1) $display("FAIL bad_err: got %b, required 1", ERR); else passed++;
    if (CPU_HOLD !== 1'b1) $display("FAIL bad_hold: got %b, required 1", CPU_HOLD); else passed++;
    if (exp_q.size() != 0) $display("FAIL bad_writes: got %0d missing, required 0", exp_q.size()); else passed++;
    send_byte(8'hA5, 1'b1);
    checks += 2;
    if (ERR !== 1'b0) $display("FAIL resync_err: got %b, required 0", ERR); else passed++;
    if (CPU_HOLD !== 1'b1) $display("FAIL resync_hold: got %b, required 1", CPU_HOLD); else passed++;
    wq.push_back(32'h20000001);
    send_body(11'h010, 1, 8'h00);
    checks += 3;
    if (done_cnt !== d0 + 1) $display("FAIL resend_done: got %0d pulses, required 1", done_cnt - d0); else passed++;
    if (ERR !== 1'b0) $display("FAIL resend_err: got %b, required 0", ERR); else passed++;
    if (CPU_HOLD !== 1'b0) $display("FAIL resend_hold: got %b, required 0", CPU_HOLD); else passed++;
  endtask

  task automatic test_frame_err();
    send_byte(8'h55, 1'b1);
    checks += 1;
    if (CPU_HOLD !== 1'b0) $display("FAIL junk_hold: got %b, required 0", CPU_HOLD); else passed++;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (4) @(negedge CLK);
    checks += 3;
    if (ERR !== 1'b1) $display("FAIL ferr_err: got %b, required 1", ERR); else passed++;
    if (dut.state_q !== StIdle) $display("FAIL ferr_state: got %0d, required idle", dut.state_q); else passed++;
    if (CPU_HOLD !== 1'b1) $display("FAIL ferr_hold: got %b, required 1", CPU_HOLD); else passed++;
  endtask

  task automatic test_timeout();
    int err_cyc;
    int bv0;
    logic seen;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    seen = 1'b0;
    err_cyc = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge CLK);
      if (ERR === 1'b1) begin
        seen = 1'b1;
        err_cyc = cyc;
      end
    end
    checks += 2;
    if (!seen) $display("FAIL timeout_seen: got no ERR within 1000 cycles, required ERR");
    else passed++;
    if (err_cyc - last_bv != int'(TMO))
      $display("FAIL timeout_delay: got %0d cycles, required %0d", err_cyc - last_bv, TMO);
    else passed++;
    bv0 = bv_cnt;
    @(negedge CLK);
    RX = 1'b0;
    repeat (3) @(negedge CLK);
    RX = 1'b1;
    repeat (40) @(negedge CLK);
    checks += 1;
    if (bv_cnt != bv0) $display("FAIL glitch: got %0d bytes, required 0", bv_cnt - bv0); else passed++;
  endtask

  task automatic test_reset_mid();
    int d0;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    checks += 4;
    if (WADDR !== 11'h000) $display("FAIL rmid_waddr: got %h, required 000", WADDR); else passed++;
    if (CPU_HOLD !== 1'b0) $display("FAIL rmid_hold: got %b, required 0", CPU_HOLD); else passed++;
    if (ERR !== 1'b0) $display("FAIL rmid_err: got %b, required 0", ERR); else passed++;
    if (WDATA !== 32'h0) $display("FAIL rmid_wdata: got %h, required 0", WDATA); else passed++;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    d0 = done_cnt;
    wq.push_back(32'hDEADBEEF);
    send_frame(11'h030, 1, 8'h00);
    checks += 3;
    if (done_cnt !== d0 + 1) $display("FAIL rmid_done: got %0d pulses, required 1", done_cnt - d0); else passed++;
    if (exp_q.size() != 0) $display("FAIL rmid_writes: got %0d missing, required 0", exp_q.size()); else passed++;
    if (WADDR !== 11'h031) $display("FAIL rmid_waddr_end: got %h, required 031", WADDR); else passed++;
  endtask

  initial begin
    RX = 1'b1;
    test_reset();
    test_single_word();
    test_wrap();
    test_bad_csum();
    test_frame_err();
    test_timeout();
    test_reset_mid();
    repeat (10) @(negedge CLK);
    checks += 1;
    if (exp_q.size() != 0) $display("FAIL final_queue: got %0d pending, required 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed + sb_passed, checks + sb_checks);
    $finish;
  end

endmodule
